// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, FSM
// state encodings and CTRL bit-field positions.
// Optional feature macro: TC_PRESCALE_EN (adds the CTRL.PSC prescaler).
package timer_counter_pkg;

    // Register offsets, selected by Addr[3:2]
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // FSM state encodings
    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    // CTRL bit-field positions
    localparam int TC_EN_BIT   = 0;
    localparam int TC_MODE_LO  = 1;
    localparam int TC_IM_BIT   = 3;
    localparam int TC_PSC_LO   = 4;

    // Mode value that selects auto-reload; every other mode is one-shot
    localparam logic [1:0] TC_MODE_RELOAD = 2'd1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: while not cleared, counts CNT cycles and emits a
// tick every psc+1 cycles. Used only when TC_PRESCALE_EN is defined.
module timer_prescaler #(
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt;

    // Tick fires on the cycle the counter reaches the programmed divider
    assign tick = (cnt == psc);

    // Divider counter; cleared outside CNT so every count phase starts fresh
    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL / PRESET / COUNT registers, a
// load/count/interrupt FSM and the combinational readback mux.
// Optional feature macro: TC_PRESCALE_EN (CTRL.PSC divides the count rate).
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0,
    parameter int          PSC_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_e        state, state_n;
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [PSC_W-1:0] psc;
    logic [31:0]      preset;
    logic [31:0]      count;
    logic             irq_flag;
    logic             tick;
    logic [1:0]       sel;
    logic             wr_ctrl, wr_preset;
    logic             step;
    logic             unused_bits;

    assign sel       = Addr[3:2];
    assign wr_ctrl   = WE && (sel == TC_CTRL);
    assign wr_preset = WE && (sel == TC_PRESET);
    // Only part of the address and data words are decoded
    assign unused_bits = ^{Addr, Din};

`ifdef TC_PRESCALE_EN
    timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state != TC_CNT),
        .psc   (psc),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
    assign psc  = '0;
`endif

    // A count step happens in an enabled CNT cycle on a prescaler tick
    assign step = (state == TC_CNT) && en && tick;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= TC_IDLE;
        else
            state <= state_n;
    end

    // FSM next-state: evaluated from register values before the edge
    always_comb begin
        state_n = state;
        case (state)
            TC_IDLE: if (en) state_n = TC_LOAD;
            TC_LOAD: state_n = TC_CNT;
            TC_CNT: begin
                if (!en)
                    state_n = TC_IDLE;
                else if (tick && count <= 32'd1)
                    state_n = TC_INT;
            end
            TC_INT:  state_n = (mode == TC_MODE_RELOAD) ? TC_LOAD : TC_IDLE;
            default: state_n = TC_IDLE;
        endcase
    end

    // Register file: FSM side effects first, bus writes last so the CPU wins
    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset   <= RESET_PRESET;
            count    <= 32'd0;
            irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
            psc      <= '0;
`endif
        end else begin
            case (state)
                TC_LOAD: begin
                    count    <= preset;
                    irq_flag <= 1'b0;
                end
                TC_CNT: begin
                    if (step) begin
                        if (count > 32'd1) begin
                            count <= count - 32'd1;
                        end else begin
                            count    <= 32'd0;
                            irq_flag <= 1'b1;
                        end
                    end
                end
                TC_INT: begin
                    if (mode == TC_MODE_RELOAD)
                        irq_flag <= 1'b0;
                    else
                        en <= 1'b0;
                end
                default: ;
            endcase
            if (wr_ctrl) begin
                en       <= Din[TC_EN_BIT];
                mode     <= Din[TC_MODE_LO +: 2];
                im       <= Din[TC_IM_BIT];
                irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
                psc      <= Din[TC_PSC_LO +: PSC_W];
`endif
            end
            if (wr_preset) begin
                preset   <= Din;
                irq_flag <= 1'b0;
            end
        end
    end

    // Readback mux; COUNT and reserved offsets are read-only
    always_comb begin
        Dout = 32'd0;
        case (sel)
            TC_CTRL: begin
                Dout[TC_EN_BIT]          = en;
                Dout[TC_MODE_LO +: 2]    = mode;
                Dout[TC_IM_BIT]          = im;
                Dout[TC_PSC_LO +: PSC_W] = psc;
            end
            TC_PRESET: Dout = preset;
            TC_COUNT:  Dout = count;
            default:   Dout = 32'd0;
        endcase
    end

    assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

    localparam logic [31:0] RST_PRE = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int total = 0;
    int passed = 0;

    timer_counter #(.RESET_PRESET(RST_PRE), .PSC_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance n edges and settle 1ns past the last one
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle bus write; returns 1ns after the write edge
    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        Addr = {28'd0, r, 2'b00};
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] d);
        Addr = {28'd0, r, 2'b00};
        #1;
        d = Dout;
    endtask

    logic [31:0] v;
    logic [31:0] exp_cnt [10] = '{3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    logic        exp_irq [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    initial begin
        reset = 1'b1; WE = 1'b0; Addr = 32'd0; Din = 32'd0;
        edges(2);
        reset = 1'b0;

        // Reset state
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, RST_PRE);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);

        // COUNT is read-only, reserved reads 0
        wr(2'd2, 32'd55);
        rd(2'd2, v); check("count_ro", v, 32'd0);
        rd(2'd3, v); check("reserved", v, 32'd0);

        // One-shot, PRESET=5: IRQ at E0+7, holds, EN cleared, PRESET write acks
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        edges(6);
        check("t1_irq_e6", {31'd0, IRQ}, 32'd0);
        rd(2'd2, v); check("t1_count_e6", v, 32'd1);
        edges(1);
        check("t1_irq_e7", {31'd0, IRQ}, 32'd1);
        edges(1);
        rd(2'd0, v); check("t1_ctrl_en0", v, 32'h8);
        check("t1_irq_hold", {31'd0, IRQ}, 32'd1);
        wr(2'd1, 32'd7);
        check("t1_irq_ack", {31'd0, IRQ}, 32'd0);

        // Auto-reload, PRESET=3: COUNT 3,2,1,0,0 and a 1-cycle IRQ every 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        edges(2);
        Addr = 32'h8;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("t2_count_%0d", i), Dout, exp_cnt[i]);
            check($sformatf("t2_irq_%0d", i), {31'd0, IRQ}, {31'd0, exp_irq[i]});
            edges(1);
        end
        wr(2'd0, 32'h0);
        edges(3);

        // PRESET=0: flag at E3, COUNT stays 0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        edges(2);
        rd(2'd2, v); check("t3_count_e2", v, 32'd0);
        check("t3_irq_e2", {31'd0, IRQ}, 32'd0);
        edges(1);
        rd(2'd2, v); check("t3_count_e3", v, 32'd0);
        check("t3_irq_e3", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h0);
        check("t3_irq_ack", {31'd0, IRQ}, 32'd0);

        // EN cleared at COUNT=10: freezes at 9, no IRQ
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        edges(12);
        rd(2'd2, v); check("t4_count10", v, 32'd10);
        wr(2'd0, 32'h8);
        edges(5);
        rd(2'd2, v); check("t4_frozen", v, 32'd9);
        check("t4_irq", {31'd0, IRQ}, 32'd0);

        // Reset mid-count at COUNT=7
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h9);
        edges(4);
        rd(2'd2, v); check("t5_count7", v, 32'd7);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        rd(2'd0, v); check("t5_ctrl", v, 32'd0);
        rd(2'd2, v); check("t5_count", v, 32'd0);
        rd(2'd1, v); check("t5_preset", v, RST_PRE);
        check("t5_irq", {31'd0, IRQ}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            edges(1);
            check($sformatf("t5_noglitch_%0d", i), {31'd0, IRQ}, 32'd0);
        end

        // Prescaler PSC=3, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h39);
        rd(2'd0, v);
`ifdef TC_PRESCALE_EN
        check("t6_psc_rd", v, 32'h39);
        edges(9);
        check("t6_irq_early", {31'd0, IRQ}, 32'd0);
        edges(1);
        check("t6_irq_e10", {31'd0, IRQ}, 32'd1);
`else
        check("t6_psc_rd", v, 32'h09);
        edges(3);
        check("t6_irq_early", {31'd0, IRQ}, 32'd0);
        edges(1);
        check("t6_irq_e4", {31'd0, IRQ}, 32'd1);
`endif

        // CPU CTRL write on the INT edge wins: EN stays 1, reload follows
        wr(2'd0, 32'h9);
        rd(2'd0, v); check("t7_ctrl_en1", v, 32'h9);
        check("t7_irq_clr", {31'd0, IRQ}, 32'd0);
        edges(3);
        check("t7_irq_early", {31'd0, IRQ}, 32'd0);
        edges(1);
        check("t7_irq_again", {31'd0, IRQ}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
